// File: rtl/rv32i_types.sv
// Shared RV32I types for the pipeline and its memory-side models.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_resp_state_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word array with one synchronous read port and one byte-lane write port.
module mem_responder_array
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk_i,
  input  logic [IDX_W-1:0] raddr_i,
  output rv32i_word        rdata_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  rv32i_word        wdata_i,
  input  logic [3:0]       be_i
);

  rv32i_word mem_q [DEPTH];
  rv32i_word rdata_q;

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the stage/memory handshake.
// Define MEM_RESP_ERR_EN to add mem_err for misaligned/out-of-range/dual requests.
module mem_responder
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  rv32i_word   mem_wdata,
  input  logic [3:0]  mem_byte_enable,
`ifdef MEM_RESP_ERR_EN
  output logic        mem_err,
`endif
  output logic        mem_resp,
  output rv32i_word   mem_rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  mem_resp_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  rv32i_word        wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;

  logic             req;
  logic             req_err;
  logic [IDX_W-1:0] addr_idx;
  logic [IDX_W-1:0] raddr;
  logic             arr_we;
  rv32i_word        arr_rdata;

  assign req      = mem_read | mem_write;
  assign addr_idx = mem_address[IDX_W+1:2];

`ifdef MEM_RESP_ERR_EN
  assign req_err = (mem_address[1:0] != 2'b00)
                 | (mem_address[31:IDX_W+2] != '0)
                 | (mem_read & mem_write);
`else
  logic unused_addr;
  assign unused_addr = ^{mem_address[31:IDX_W+2], mem_address[1:0]};
  assign req_err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = mem_write;
          err_d   = req_err;
          idx_d   = addr_idx;
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // IDLE reads straight from the inputs so LATENCY=1 still has data ready
  assign raddr  = (state_q == IDLE) ? addr_idx : idx_q;
  assign arr_we = (state_q == RESP) & we_q & ~err_q;

  mem_responder_array #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk),
    .raddr_i (raddr),
    .rdata_o (arr_rdata),
    .we_i    (arr_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .be_i    (be_q)
  );

  assign mem_resp  = (state_q == RESP);
  assign mem_rdata = (mem_resp & ~we_q & ~err_q) ? arr_rdata : '0;

`ifdef MEM_RESP_ERR_EN
  assign mem_err = mem_resp & err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder, LATENCY=2, DEPTH_WORDS=256.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int n_cmp;
  int n_bad;

  mem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
`ifdef MEM_RESP_ERR_EN
    .mem_err         (mem_err),
`endif
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata)
  );

`ifndef MEM_RESP_ERR_EN
  assign mem_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request at a negedge; wait (bounded) for the resp pulse.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     output int lat, output logic [31:0] rdata,
                     output logic err);
    @(negedge clk);
    mem_read = rd;
    mem_write = wr;
    mem_address = a;
    mem_wdata = d;
    mem_byte_enable = be;
    lat = -1;
    rdata = 32'hFFFF_FFFF;
    err = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        lat = i;
        rdata = mem_rdata;
        err = mem_err;
        break;
      end
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mem_resp !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_resp got %b exp 0", mem_resp);
    end
    n_cmp++;
    if (mem_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rdata got %h exp 0", mem_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] rd;
    logic e;
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, e);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL wr_latency got %0d exp 2", lat);
    end
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL rd_latency got %0d exp 2", lat);
    end
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL rd_data got %h exp deadbeef", rd);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rdata_idle got %h exp 0", mem_rdata);
    end
  endtask

  task automatic test_byte_enable();
    int lat;
    logic [31:0] rd;
    logic e;
    txn(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, lat, rd, e);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e);
    n_cmp++;
    if (rd !== 32'hDEADBEAA) begin
      n_bad++;
      $display("FAIL byte_en got %h exp deadbeaa", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int nresp;
    int first;
    int second;
    logic [31:0] rd;
    logic [31:0] rd2;
    logic e;
    txn(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, lat, rd, e);
    // held through the IDLE cycle: a second accept is expected
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 32'h20;
    nresp = 0;
    first = 0;
    second = 0;
    rd2 = 32'h0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        nresp++;
        if (first == 0) first = i;
        else second = i;
        rd2 = mem_rdata;
      end
      if (i == 4) mem_read = 1'b0;
    end
    n_cmp++;
    if (nresp !== 2) begin
      n_bad++;
      $display("FAIL b2b_count got %0d exp 2", nresp);
    end
    n_cmp++;
    if (first !== 2 || second !== 5) begin
      n_bad++;
      $display("FAIL b2b_timing got %0d,%0d exp 2,5", first, second);
    end
    n_cmp++;
    if (rd2 !== 32'h12345678) begin
      n_bad++;
      $display("FAIL b2b_data got %h exp 12345678", rd2);
    end
    // dropped in the cycle after resp: exactly one resp
    @(negedge clk);
    mem_read = 1'b1;
    nresp = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_resp) nresp++;
      if (i == 3) mem_read = 1'b0;
    end
    n_cmp++;
    if (nresp !== 1) begin
      n_bad++;
      $display("FAIL single_count got %0d exp 1", nresp);
    end
  endtask

  task automatic test_drop();
    int lat;
    logic [31:0] rd;
    logic e;
    logic r1;
    logic r2;
    logic [31:0] d2;
    logic w1;
    logic w2;
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 32'h10;
    @(negedge clk);
    mem_read = 1'b0;
    r1 = mem_resp;
    @(negedge clk);
    r2 = mem_resp;
    d2 = mem_rdata;
    n_cmp++;
    if (r1 !== 1'b0 || r2 !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_resp got %b%b exp 01", r1, r2);
    end
    n_cmp++;
    if (d2 !== 32'hDEADBEAA) begin
      n_bad++;
      $display("FAIL drop_data got %h exp deadbeaa", d2);
    end
    @(negedge clk);
    mem_write = 1'b1;
    mem_address = 32'h40;
    mem_wdata = 32'hCAFEF00D;
    mem_byte_enable = 4'hF;
    @(negedge clk);
    mem_write = 1'b0;
    w1 = mem_resp;
    @(negedge clk);
    w2 = mem_resp;
    n_cmp++;
    if (w1 !== 1'b0 || w2 !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_next_wr got %b%b exp 01", w1, w2);
    end
    txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, e);
    n_cmp++;
    if (rd !== 32'hCAFEF00D) begin
      n_bad++;
      $display("FAIL drop_next_rd got %h exp cafef00d", rd);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int nresp;
    logic [31:0] rd;
    logic e;
    txn(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, lat, rd, e);
    @(negedge clk);
    mem_write = 1'b1;
    mem_address = 32'h30;
    mem_wdata = 32'h00000055;
    mem_byte_enable = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    mem_write = 1'b0;
    #1;
    n_cmp++;
    if (mem_resp !== 1'b0 || mem_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid got %b/%h exp 0/0", mem_resp, mem_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    nresp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_resp) nresp++;
    end
    n_cmp++;
    if (nresp !== 0) begin
      n_bad++;
      $display("FAIL rst_no_resp got %0d exp 0", nresp);
    end
    txn(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, lat, rd, e);
    n_cmp++;
    if (rd !== 32'h0BADF00D) begin
      n_bad++;
      $display("FAIL rst_no_commit got %h exp 0badf00d", rd);
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [31:0] rd;
    logic e;
    logic [31:0] exp_rd;
    logic exp_err;
`ifdef MEM_RESP_ERR_EN
    exp_rd = 32'h77777777;
    exp_err = 1'b1;
`else
    exp_rd = 32'h00000011;
    exp_err = 1'b0;
`endif
    txn(1'b0, 1'b1, 32'h000, 32'h77777777, 4'hF, lat, rd, e);
    txn(1'b0, 1'b1, 32'h400, 32'h00000011, 4'hF, lat, rd, e);
    n_cmp++;
    if (lat !== 2 || e !== exp_err) begin
      n_bad++;
      $display("FAIL wrap_wr got lat %0d err %b exp 2 %b", lat, e, exp_err);
    end
    txn(1'b1, 1'b0, 32'h000, 32'h0, 4'h0, lat, rd, e);
    n_cmp++;
    if (rd !== exp_rd || e !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_rd got %h err %b exp %h 0", rd, e, exp_rd);
    end
    txn(1'b1, 1'b1, 32'h10, 32'h00000000, 4'hF, lat, rd, e);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e);
`ifdef MEM_RESP_ERR_EN
    exp_rd = 32'hDEADBEAA;
`else
    exp_rd = 32'h00000000;
`endif
    n_cmp++;
    if (rd !== exp_rd) begin
      n_bad++;
      $display("FAIL rw_both got %h exp %h", rd, exp_rd);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = 32'h0;
    mem_wdata = 32'h0;
    mem_byte_enable = 4'h0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
